gemm_write_back: RTL
====================

Name: gemm_write_back

Overview:
- Final (WB) stage of the GEMM core pipeline. It is the writer counterpart of the memory-read stage.
- Accepts one result per cycle from the EX stage: a 16-lane accumulator tensor plus its destination index.
- Buffers results in a 2-entry FIFO and writes each one to the accumulator memory (full 32-bit lanes) and to the output buffer (narrowed 8-bit lanes).
- Provides a forwarding lookup so the read stage can resolve read-after-write hazards on entries that are accepted but not yet written.

Parameters:
- INP_WIDTH, 8, output lane width
- ACC_WIDTH, 32, accumulator lane width
- IT_WIDTH, INP_WIDTH*16, output tensor width
- AT_WIDTH, ACC_WIDTH*16, accumulator tensor width
- A_IDX_WIDTH, 12, accumulator/output index width
- CNT_WIDTH, 16, write counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- wb_valid  in  1  EX result valid
- wb_ready  out  1  stage can accept a result
- wb_dst_idx  in  A_IDX_WIDTH  destination index
- wb_acc  in  AT_WIDTH  accumulator tensor
- wb_last  in  1  result is the final uop of the current instruction
- mem_wr_ready  in  1  accumulator and output memories accept a write this cycle
- acc_wr_en  out  1  accumulator write strobe
- acc_wr_addr  out  A_IDX_WIDTH  accumulator write address
- acc_wr_data  out  AT_WIDTH  accumulator write data
- out_wr_en  out  1  output buffer write strobe
- out_wr_addr  out  A_IDX_WIDTH  output write address
- out_wr_data  out  IT_WIDTH  narrowed output data
- fwd_query_idx  in  A_IDX_WIDTH  index requested by the read stage
- fwd_hit  out  1  a pending entry matches fwd_query_idx
- fwd_data  out  AT_WIDTH  data of the youngest matching entry
- done  out  1  one-cycle pulse when the last write of an instruction is issued
- wr_count  out  CNT_WIDTH  total writes issued

Behaviour:
- Reset and clocking: one clock (clk); reset rst is asynchronous and active-low. Asserting rst, including mid-operation, immediately empties the FIFO and forces every output to 0. In-flight entries are discarded and no write is issued. wb_ready is 0 during reset and 1 from the first cycle after release.
- Accept: a transfer occurs on a clk edge with wb_valid & wb_ready. wb_ready = (occupancy < 2), registered and independent of mem_wr_ready. No combinational path from mem_wr_ready to wb_ready.
- Narrowing: out lane i = acc lane i [INP_WIDTH-1:0] (two's-complement truncation). It is computed at push and stored alongside the entry.
- Issue:
  - acc_wr_en = out_wr_en = (occupancy > 0) & mem_wr_ready. Both are combinational from registered head state and always equal.
  - Addresses and data always reflect the FIFO head; they are 0 when the FIFO is empty.
  - A write is consumed (pop) on the edge where the enables are high.
- Latency: a result accepted at edge N is presented at the head from cycle N+1. It is written at the first edge at or after N+1 with mem_wr_ready=1.
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1 and order is preserved.
  - Occupancy 2: no push can occur because wb_ready=0.
  - Occupancy 0: no pop; the pushed entry becomes head next cycle. There is no zero-cycle bypass.
- Forwarding:
  - fwd_hit / fwd_data are combinational and compare fwd_query_idx against valid FIFO entries only.
  - The youngest match wins. An entry being pushed in the same cycle is not visible.
  - The head remains visible during its pop cycle.
  - With no match, fwd_hit=0 and fwd_data=0.
- done: a registered pulse asserted the cycle after a pop of an entry whose stored last flag is 1. Consecutive last entries give consecutive pulses.
- wr_count: increments by 1 per pop and wraps modulo 2^CNT_WIDTH. It is cleared only by reset.
- Index width: the FIFO stores the full A_IDX_WIDTH index; no address arithmetic is performed.

Optional Feature:
- Macro: GEMM_WB_SAT_EN.
- Defined: the narrowing step saturates each signed ACC_WIDTH lane to the signed INP_WIDTH range. For 8-bit lanes, values > 127 become 127 and values < -128 become -128; otherwise the low bits are used. acc_wr_data is unchanged (full precision).
- Undefined: plain truncation as above.
- Port list, latency and FIFO depth are identical in both builds.

Decomposition:
- Shared package gemm_pkg:
  - width constants INP_WIDTH, ACC_WIDTH, A_IDX_WIDTH, lane count 16
  - wb_entry_t struct {last, dst_idx, acc, out}
  - a narrowing function (truncate or saturate, selected by the macro)
- One sub-module: gemm_wb_fifo, a generic 2-entry FIFO with an occupancy count and per-entry visibility for the forwarding search. The narrowing lanes are generate-loop logic in the top.

Test Plan:
- Single result: wb_acc lane0=0x0000_0105, dst=0x012, mem_wr_ready=1 -> next cycle acc_wr_en=1, addr 0x012, out lane0=0x05; wr_count=1.
- Backpressure: 3 results pushed in consecutive cycles with mem_wr_ready=0 -> wb_ready drops after 2 accepts and the third is held. Raise ready -> writes issue in order 0,1,2 on consecutive cycles.
- Forwarding: pending entries dst=0x040 (data A), then 0x040 (data B); query 0x040 -> fwd_hit=1 with data B. Query 0x041 -> fwd_hit=0, fwd_data=0.
- Last/done: 4 results with wb_last only on the 4th -> done pulses exactly once, the cycle after the 4th write.
- Async reset with occupancy 2 mid-stall -> all outputs 0 immediately, no writes after release, wr_count=0.
- With GEMM_WB_SAT_EN: lane = 0x0000_0200 -> out 0x7F; lane = 0xFFFF_FF00 -> out 0x80. Without it: 0x00 and 0x00.

Source files
------------

// File: rtl/gemm_pkg.sv
// ---------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the GEMM core write-back stage.
//   - Width constants for the output and accumulator tensors and the index.
//   - wb_entry_t: one buffered write-back result. The narrowed output lanes
//     are stored next to the full accumulator lanes.
//   - narrow_lane(): reduces one accumulator lane to an output lane.
// Build option:
//   GEMM_WB_SAT_EN  defined   -> narrow_lane saturates to the signed
//                                output range
//                   undefined -> narrow_lane truncates (two's complement)
// ---------------------------------------------------------------------------
package gemm_pkg;

    localparam int INP_WIDTH   = 8;
    localparam int ACC_WIDTH   = 32;
    localparam int LANES       = 16;
    localparam int IT_WIDTH    = INP_WIDTH * LANES;
    localparam int AT_WIDTH    = ACC_WIDTH * LANES;
    localparam int A_IDX_WIDTH = 12;
    localparam int CNT_WIDTH   = 16;

    typedef struct packed {
        logic                   last;
        logic [A_IDX_WIDTH-1:0] dst_idx;
        logic [AT_WIDTH-1:0]    acc;
        logic [IT_WIDTH-1:0]    out;
    } wb_entry_t;

`ifdef GEMM_WB_SAT_EN
    // Signed output range expressed at accumulator width for the compare.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (1 <<< (INP_WIDTH - 1)) - 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

    function automatic logic [INP_WIDTH-1:0] narrow_lane(
        input logic signed [ACC_WIDTH-1:0] v
    );
`ifdef GEMM_WB_SAT_EN
        if (v > SAT_MAX) begin
            return SAT_MAX[INP_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[INP_WIDTH-1:0];
        end else begin
            return v[INP_WIDTH-1:0];
        end
`else
        return v[INP_WIDTH-1:0];
`endif
    endfunction

endpackage

// File: rtl/gemm_wb_fifo.sv
// ---------------------------------------------------------------------------
// gemm_wb_fifo
// Generic 2-entry FIFO. slot0 always holds the oldest entry (the head) and
// slot1 the younger one, so the forwarding search can resolve the youngest
// match without tracking pointers.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (clears occupancy)
//   push, din     write an entry (caller never pushes when full)
//   pop           drop the head (caller never pops when empty)
//   count         current occupancy, 0..2
//   slot0, slot1  head entry and the entry behind it
//   vld           per-slot visibility: vld[0] head valid, vld[1] second valid
// ---------------------------------------------------------------------------
module gemm_wb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] slot0,
    output logic [W-1:0] slot1,
    output logic [1:0]   vld
);

    // Occupancy is the only control state; it alone defines which slots hold
    // meaningful data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage: on pop the second entry (or a simultaneous push) shifts into
    // the head; a push without pop fills the first free slot.
    always_ff @(posedge clk) begin
        if (pop) begin
            slot0 <= (count == 2'd2) ? slot1 : din;
        end else if (push) begin
            if (count == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
        end
    end

    assign vld = {count == 2'd2, count != 2'd0};

endmodule

// File: rtl/gemm_write_back.sv
// ---------------------------------------------------------------------------
// gemm_write_back
// Final (WB) stage of the GEMM core pipeline. Results from EX are buffered
// in a 2-entry FIFO and written to the accumulator memory (full lanes) and
// the output buffer (narrowed lanes). Pending entries can be looked up by the
// read stage to resolve read-after-write hazards.
// Build option: GEMM_WB_SAT_EN selects saturating narrowing (see gemm_pkg);
//   without it lanes are truncated. Ports and timing are identical.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wb_valid/wb_ready        EX handshake; wb_ready is registered
//   wb_dst_idx/wb_acc/wb_last result index, accumulator tensor, last flag
//   mem_wr_ready             memories accept a write this cycle
//   acc_wr_*                 accumulator memory write port
//   out_wr_*                 output buffer write port (narrowed data)
//   fwd_query_idx/fwd_hit/fwd_data  forwarding lookup (combinational)
//   done                     pulse the cycle after the last write of an instr
//   wr_count                 free-running count of issued writes
// ---------------------------------------------------------------------------
module gemm_write_back
    import gemm_pkg::*;
#(
    parameter int INP_WIDTH   = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int IT_WIDTH    = INP_WIDTH * 16,
    parameter int AT_WIDTH    = ACC_WIDTH * 16,
    parameter int A_IDX_WIDTH = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [A_IDX_WIDTH-1:0] wb_dst_idx,
    input  logic [AT_WIDTH-1:0]    wb_acc,
    input  logic                   wb_last,
    input  logic                   mem_wr_ready,
    output logic                   acc_wr_en,
    output logic [A_IDX_WIDTH-1:0] acc_wr_addr,
    output logic [AT_WIDTH-1:0]    acc_wr_data,
    output logic                   out_wr_en,
    output logic [A_IDX_WIDTH-1:0] out_wr_addr,
    output logic [IT_WIDTH-1:0]    out_wr_data,
    input  logic [A_IDX_WIDTH-1:0] fwd_query_idx,
    output logic                   fwd_hit,
    output logic [AT_WIDTH-1:0]    fwd_data,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   wr_count
);

    localparam int NLANES = AT_WIDTH / ACC_WIDTH;

    logic [IT_WIDTH-1:0] narrow;
    wb_entry_t           push_entry;
    wb_entry_t           head;
    wb_entry_t           second;
    logic [1:0]          occ;
    logic [1:0]          vld;
    logic [1:0]          occ_nxt;
    logic                push;
    logic                pop;
    logic                unused_second;

    // Narrowing happens at push so the stored entry is write-ready.
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign narrow[i*INP_WIDTH +: INP_WIDTH] =
            narrow_lane(wb_acc[i*ACC_WIDTH +: ACC_WIDTH]);
    end

    assign push_entry = '{last: wb_last, dst_idx: wb_dst_idx, acc: wb_acc, out: narrow};

    assign push = wb_valid & wb_ready;
    assign pop  = vld[0] & mem_wr_ready;

    gemm_wb_fifo #(
        .W ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .count (occ),
        .slot0 (head),
        .slot1 (second),
        .vld   (vld)
    );

    // Only the index and accumulator data of the second slot feed forwarding.
    assign unused_second = ^{second.last, second.out};

    // Issue: enables are a function of registered head state and the memory
    // ready only; data is masked to zero when nothing is pending.
    assign acc_wr_en   = pop;
    assign out_wr_en   = pop;
    assign acc_wr_addr = vld[0] ? head.dst_idx : '0;
    assign out_wr_addr = vld[0] ? head.dst_idx : '0;
    assign acc_wr_data = vld[0] ? head.acc     : '0;
    assign out_wr_data = vld[0] ? head.out     : '0;

    // Forwarding: the second slot is younger, so its match overrides the head.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (vld[0] && (head.dst_idx == fwd_query_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = head.acc;
        end
        if (vld[1] && (second.dst_idx == fwd_query_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = second.acc;
        end
    end

    // Ready is registered from next-cycle occupancy, keeping mem_wr_ready out
    // of the combinational path to wb_ready.
    assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};

    // Registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ready <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
        end else begin
            wb_ready <= (occ_nxt < 2'd2);
            done     <= pop & head.last;
            if (pop) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule
